// File: rtl/hazard_if.sv
// hazard_if: pipeline <-> hazard unit bundle (register ids, control in; stall/flush/forward, status out)
// master = pipeline side, slave = hazard_ctrl side; CNT_W sizes the performance counters.
interface hazard_if #(parameter int CNT_W = 32);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_timeout, stall_cycles, flush_events
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline hazard unit with memory-wait FSM, watchdog and saturating counters
// Ports: clk; rst (async, active-low); hif (slave) carries register ids, controls and all outputs.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hif
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             mem_stall, lw_stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    mem_stall = 1'b1;
    case (state_q)
      RUN: begin
        mem_stall = hif.MemReqM && !hif.MemReadyM;
        if (mem_stall) begin
          state_d = WAIT;
          wcnt_d  = WW'(1);
        end
      end
      WAIT: begin
        mem_stall = !hif.MemReadyM;
        if (hif.MemReadyM) state_d = RUN;
        else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end else wcnt_d = wcnt_q + WW'(1);
      end
      default: mem_stall = 1'b1;
    endcase
  end
  assign lw_stall = hif.ResultSrcE == 2'b01 && hif.RdE != 5'd0 &&
                    (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
  // a redirect in E discards the D instruction, so it overrides the load-use stall
  assign hif.StallF = mem_stall || (!hif.PCSrcE && lw_stall);
  assign hif.StallD = hif.StallF;
  assign hif.StallE = mem_stall;
  assign hif.StallM = mem_stall;
  assign hif.FlushW = mem_stall;
  assign hif.FlushD = !mem_stall && hif.PCSrcE;
  assign hif.FlushE = !mem_stall && (hif.PCSrcE || lw_stall);
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (hif.RegWriteM && hif.RdM != 5'd0 && hif.RdM == rs) ? 2'b10 :
           (hif.RegWriteW && hif.RdW != 5'd0 && hif.RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  assign hif.ForwardAE = fwd(hif.Rs1E);
  assign hif.ForwardBE = fwd(hif.Rs2E);
  always_comb begin
    stall_d = (hif.StallF && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (hif.FlushE && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
  end
  assign hif.mem_timeout  = timeout_q;
  assign hif.stall_cycles = stall_q;
  assign hif.flush_events = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int TO = 4, CW = 4, SAT = 15;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  hazard_if #(.CNT_W(CW)) hif();
  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut(.clk(clk), .rst(rst), .hif(hif));
  int compared = 0, mismatched = 0;
  int m_n, m_sc, m_fc;
  bit m_err;
  logic [10:0] obs;
  assign obs = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
                hif.FlushW, hif.ForwardAE, hif.ForwardBE};

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
    if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // n = memory-stalled cycles so far in the current access; err = watchdog fired
  function automatic logic [10:0] expv();
    bit ms = m_err || (!hif.MemReadyM && (hif.MemReqM || m_n > 0));
    bit lw = hif.ResultSrcE == 2'b01 && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
    logic [6:0] c;
    if (ms) c = 7'b1111001;
    else if (hif.PCSrcE) c = 7'b0000110;
    else if (lw) c = 7'b1100010;
    else c = 7'b0;
    return {c, fwd(hif.Rs1E), fwd(hif.Rs2E)};
  endfunction

  task automatic tick();
    logic [10:0] e;
    e = expv();
    @(posedge clk);
    if (!m_err) begin
      if (e[7]) begin
        m_n++;
        if (m_n == TO) m_err = 1;
      end else m_n = 0;
    end
    if (e[10] && m_sc < SAT) m_sc++;
    if (e[5] && m_fc < SAT) m_fc++;
    #1;
  endtask

  task automatic zero_inputs();
    {hif.Rs1D, hif.Rs2D, hif.Rs1E, hif.Rs2E, hif.RdE, hif.RdM, hif.RdW} = '0;
    hif.ResultSrcE = 0;
    {hif.RegWriteM, hif.RegWriteW, hif.PCSrcE, hif.MemReqM, hif.MemReadyM} = '0;
  endtask

  task automatic apply_reset();
    rst = 0;
    zero_inputs();
    m_n = 0; m_err = 0; m_sc = 0; m_fc = 0;
    #2 rst = 1;
  endtask

  task automatic rand_regs();
    hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
    hif.Rs1E = 5'($urandom_range(0, 3)); hif.Rs2E = 5'($urandom_range(0, 3));
    hif.RdE = 5'($urandom_range(0, 3)); hif.RdM = 5'($urandom_range(0, 3));
    hif.RdW = 5'($urandom_range(0, 3));
    hif.ResultSrcE = 2'($urandom_range(0, 3));
    hif.RegWriteM = 1'($urandom); hif.RegWriteW = 1'($urandom);
    hif.PCSrcE = $urandom_range(0, 3) == 0;
  endtask

  task automatic test_reset();
    rst = 0;
    zero_inputs();
    m_n = 0; m_err = 0; m_sc = 0; m_fc = 0;
    #1;
    compared++;
    if (obs !== 11'b0) begin mismatched++; $display("FAIL reset_ctrl obs=%b exp=%b", obs, 11'b0); end
    compared++;
    if ({hif.mem_timeout, hif.stall_cycles, hif.flush_events} !== '0) begin
      mismatched++;
      $display("FAIL reset_state timeout=%b stall=%0d flush=%0d exp=0", hif.mem_timeout, hif.stall_cycles, hif.flush_events);
    end
    #2 rst = 1;
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    hif.ResultSrcE = 2'b01; hif.RdE = 5; hif.Rs1D = 5;
    #1;
    compared++;
    if (obs !== 11'b11000100000) begin mismatched++; $display("FAIL lu_stall obs=%b exp=%b", obs, 11'b11000100000); end
    tick();
    hif.RdE = 0; hif.Rs1D = 0;
    #1;
    compared++;
    if (obs !== 11'b0) begin mismatched++; $display("FAIL lu_rd0 obs=%b exp=%b", obs, 11'b0); end
    tick();
    for (int i = 0; i < 40; i++) begin
      rand_regs();
      #1;
      compared++;
      if (obs !== expv()) begin mismatched++; $display("FAIL lu_rand obs=%b exp=%b", obs, expv()); end
      tick();
    end
  endtask

  task automatic test_forward();
    apply_reset();
    hif.RegWriteM = 1; hif.RegWriteW = 1; hif.RdM = 7; hif.RdW = 7; hif.Rs1E = 7;
    #1;
    compared++;
    if (hif.ForwardAE !== 2'b10) begin mismatched++; $display("FAIL fwd_m got=%b exp=10", hif.ForwardAE); end
    hif.RegWriteM = 0;
    #1;
    compared++;
    if (hif.ForwardAE !== 2'b01) begin mismatched++; $display("FAIL fwd_w got=%b exp=01", hif.ForwardAE); end
    hif.Rs2E = 0; hif.RdW = 0;
    #1;
    compared++;
    if (hif.ForwardBE !== 2'b00) begin mismatched++; $display("FAIL fwd_x0 got=%b exp=00", hif.ForwardBE); end
    tick();
  endtask

  task automatic test_branch_lw();
    apply_reset();
    hif.PCSrcE = 1; hif.ResultSrcE = 2'b01; hif.RdE = 3; hif.Rs2D = 3;
    #1;
    compared++;
    if (obs !== 11'b00001100000) begin mismatched++; $display("FAIL br_lw obs=%b exp=%b", obs, 11'b00001100000); end
    tick();
    compared++;
    if (hif.flush_events !== CW'(m_fc) || m_fc != 1) begin
      mismatched++; $display("FAIL br_flush_cnt got=%0d exp=%0d", hif.flush_events, m_fc);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    hif.MemReqM = 1; hif.PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (obs !== 11'b11110010000) begin mismatched++; $display("FAIL mw_stall%0d obs=%b exp=%b", i, obs, 11'b11110010000); end
      tick();
    end
    hif.MemReadyM = 1;
    #1;
    compared++;
    if (obs !== 11'b00001100000) begin mismatched++; $display("FAIL mw_release obs=%b exp=%b", obs, 11'b00001100000); end
    tick();
    hif.MemReqM = 0; hif.PCSrcE = 0;
    #1;
    compared++;
    if (hif.stall_cycles !== 4'd3 || m_sc != 3) begin mismatched++; $display("FAIL mw_count got=%0d exp=3", hif.stall_cycles); end
    compared++;
    if (obs !== 11'b0) begin mismatched++; $display("FAIL mw_idle obs=%b exp=0", obs); end
  endtask

  task automatic test_timeout();
    apply_reset();
    hif.MemReqM = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      compared++;
      if (hif.mem_timeout !== (i >= TO) || hif.mem_timeout !== m_err) begin
        mismatched++; $display("FAIL to_flag%0d got=%b exp=%b", i, hif.mem_timeout, m_err);
      end
      compared++;
      if (obs !== expv()) begin mismatched++; $display("FAIL to_ctrl%0d obs=%b exp=%b", i, obs, expv()); end
      tick();
    end
    hif.MemReadyM = 1; hif.MemReqM = 0;
    #1;
    compared++;
    if (obs !== 11'b11110010000 || hif.mem_timeout !== 1'b1) begin
      mismatched++; $display("FAIL to_ready_ignored obs=%b timeout=%b", obs, hif.mem_timeout);
    end
    tick();
    #2 rst = 0;
    m_n = 0; m_err = 0; m_sc = 0; m_fc = 0;
    #1;
    compared++;
    if ({obs, hif.mem_timeout, hif.stall_cycles, hif.flush_events} !== '0) begin
      mismatched++; $display("FAIL to_async_rst obs=%b timeout=%b stall=%0d", obs, hif.mem_timeout, hif.stall_cycles);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    hif.MemReqM = 1;
    tick(); tick();
    hif.MemReqM = 0;
    #1;
    compared++;
    if (obs[10:7] !== 4'hF) begin mismatched++; $display("FAIL rw_waiting stalls=%b exp=1111", obs[10:7]); end
    rst = 0;
    m_n = 0; m_err = 0; m_sc = 0; m_fc = 0;
    #1;
    compared++;
    if (obs[10:7] !== 4'h0 || hif.mem_timeout !== 1'b0) begin
      mismatched++; $display("FAIL rw_reset stalls=%b timeout=%b exp=0", obs[10:7], hif.mem_timeout);
    end
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (obs !== expv() || hif.mem_timeout !== 1'b0) begin
        mismatched++; $display("FAIL rw_after obs=%b exp=%b timeout=%b", obs, expv(), hif.mem_timeout);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    hif.MemReqM = 1;
    repeat (20) tick();
    compared++;
    if (hif.stall_cycles !== 4'd15 || m_sc != SAT) begin
      mismatched++; $display("FAIL sat_count got=%0d exp=15", hif.stall_cycles);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_err && $urandom_range(0, 3) == 0) apply_reset();
      rand_regs();
      hif.MemReqM = $urandom_range(0, 2) == 0;
      hif.MemReadyM = $urandom_range(0, 2) != 0;
      #1;
      compared++;
      if (obs !== expv()) begin mismatched++; $display("FAIL rnd_ctrl obs=%b exp=%b", obs, expv()); end
      compared++;
      if (hif.mem_timeout !== m_err || hif.stall_cycles !== CW'(m_sc) || hif.flush_events !== CW'(m_fc)) begin
        mismatched++;
        $display("FAIL rnd_state timeout=%b/%b stall=%0d/%0d flush=%0d/%0d", hif.mem_timeout, m_err,
                 hif.stall_cycles, m_sc, hif.flush_events, m_fc);
      end
      tick();
    end
  endtask

  initial begin
    zero_inputs();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_forward();
    test_branch_lw();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage RISC-V core.
- Drives the stall and clear inputs of the F, D/E, E/M and M/W pipeline registers, and the ALU operand forwarding muxes.
- Detects load-use hazards and branch/jump redirects from the register outputs.
- Runs a memory-wait FSM with a watchdog timeout for the variable-latency data memory, plus saturating performance counters.

Parameters:
- TIMEOUT, 64, maximum number of consecutive wait cycles on data memory before entering the error state (must be ≥ 2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- Rs1D, Rs2D  input  5  source registers in D.
- Rs1E, Rs2E, RdE  input  5  source and destination registers in E.
- RdM, RdW  input  5  destination registers in M and W.
- ResultSrcE  input  2  result select in E; 2'b01 means load.
- RegWriteM, RegWriteW  input  1  register-write enables in M and W.
- PCSrcE  input  1  taken branch, jal or jalr in E.
- MemReqM  input  1  load or store in M.
- MemReadyM  input  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  output  1  hold the PC or the corresponding pipeline register.
- FlushD, FlushE, FlushW  output  1  clear (bubble) the F/D, D/E and M/W registers.
- ForwardAE, ForwardBE  output  2  forwarding select: 00 = register file, 01 = W result, 10 = M ALU result.
- mem_timeout  output  1  sticky error flag.
- stall_cycles  output  CNT_W  count of cycles with StallF high.
- flush_events  output  CNT_W  count of cycles with FlushE high.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM returns to RUN; wait counter = 0.
  - mem_timeout = 0; both counters = 0.
  - Combinational outputs follow their inputs from the reset state; with MemReqM=0 all stalls and flushes are 0 and forwards are 00.
- FSM states:
  - RUN: if MemReqM && !MemReadyM, go to WAIT and set wcnt = 1.
  - WAIT: if MemReadyM, go to RUN. Else if wcnt == TIMEOUT-1, go to ERR and set mem_timeout = 1. Else wcnt += 1.
  - ERR: terminal until reset; MemReadyM is ignored.
- memStall:
  - In RUN: MemReqM && !MemReadyM.
  - In WAIT: !MemReadyM.
  - In ERR: 1.
  - Release is combinational in the cycle MemReadyM rises, so there is zero extra latency.
- lwStall = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D).
- Priority, highest first:
  1. memStall: StallF = StallD = StallE = StallM = 1; FlushW = 1; FlushD = FlushE = 0. The frozen E stage keeps PCSrcE and lwStall conditions until release; they are acted on in the release cycle.
  2. PCSrcE: FlushD = 1 and FlushE = 1; StallF = StallD = 0, even if lwStall is also true, because the redirect discards the D instruction.
  3. lwStall: StallF = StallD = 1 and FlushE = 1.
  - Otherwise all stalls and flushes are 0.
- Forwarding (ForwardAE, ForwardBE):
  - 10 if RegWriteM && RdM != 0 && RdM == Rs1E (Rs2E for B).
  - Else 01 if RegWriteW && RdW != 0 && RdW == Rs1E (Rs2E).
  - Else 00.
  - M beats W when both match. Forwarding remains active during memStall.
- Counters:
  - Each increments by 1 on the clock edge when its condition is high.
  - Each saturates at 2^CNT_W - 1 with no wrap.
- Reset asserted mid-WAIT: the FSM is in RUN immediately, all stalls drop, and no timeout is flagged.

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle. With RdE=0 instead → no stall.
- Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=7 → ForwardAE=10. Clear RegWriteM → 01. Set Rs2E=0 with RdW=0 → ForwardBE=00.
- Branch plus load-use in the same cycle: PCSrcE=1 and the lwStall condition true → FlushD=FlushE=1, StallF=0. flush_events increments by 1.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high → all stalls and FlushW high for exactly 3 cycles, low in the ready cycle. The FSM passes RUN→WAIT→RUN, and stall_cycles = 3. Also: a PCSrcE held during the wait produces its flush only in the release cycle.
- Timeout: TIMEOUT=4 with MemReadyM held low → mem_timeout rises on the edge after the 4th stalled cycle. Stalls stay high and a later MemReadyM=1 has no effect. Asserting rst low clears everything asynchronously.
- Counter saturation: CNT_W=4 with 20 continuous stall cycles → stall_cycles holds at 15.
